// File: rtl/axi3_uncached_wbuf_pkg.sv
// ============================================================================
// axi3_uncached_wbuf_pkg : shared types and AXI3 constants for the uncached
//                          posted-write buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package axi3_uncached_wbuf_pkg;

    typedef logic [31:0] phys_t;
    typedef logic [31:0] uint32_t;

    typedef struct packed {
        phys_t       addr;
        logic [3:0]  be;
        uint32_t     data;
    } wbuf_entry_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef struct packed {
        logic        awvalid;
        phys_t       awaddr;
        logic [3:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic [1:0]  awlock;
        logic [3:0]  awcache;
        logic [2:0]  awprot;
        logic        wvalid;
        uint32_t     wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        bready;
    } axi3_wr_req_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic        bvalid;
        logic [1:0]  bresp;
    } axi3_wr_resp_t;

endpackage

`default_nettype wire

// File: rtl/axi3_uncached_wbuf_sync_fifo.sv
// ============================================================================
// sync_fifo : pointer-based FIFO exposing per-entry valid bits and raw storage
//             so the parent can search every queued entry.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [31:0]
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  T                 i_data,
    input  logic             i_pop,
    output T                 o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [DEPTH-1:0] o_valid,
    output T                 o_mem [DEPTH]
);

    localparam int AW = $clog2(DEPTH);

    T              r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   w_count;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_mem   = r_mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push && !o_full)
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (i_pop && !o_empty)
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !o_full)
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    // An entry is live when its distance from the read pointer is below the count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
        logic [AW-1:0] w_off;
        assign w_off       = AW'(gi) - r_rd_ptr[AW-1:0];
        assign o_valid[gi] = ({1'b0, w_off} < w_count);
    end

endmodule

`default_nettype wire

// File: rtl/axi3_uncached_wbuf.sv
// ============================================================================
// axi3_uncached_wbuf : posted-write buffer for uncached stores, drained in
//                      order as single-beat AXI3 writes with bounded B credit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi3_uncached_wbuf
    import axi3_uncached_wbuf_pkg::*;
#(
    parameter int DEPTH           = 8,
    parameter int ID_WIDTH        = 4,
    parameter int AXI_ID          = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_push_valid,
    output logic                o_push_ready,
    input  phys_t               i_push_addr,
    input  logic [3:0]          i_push_be,
    input  uint32_t             i_push_data,
    input  phys_t               i_query_addr,
    output logic                o_query_hit,
    output logic                o_drained,
    output logic                o_bus_err,
    output axi3_wr_req_t        o_axi3_wr_req,
    input  axi3_wr_resp_t       i_axi3_wr_resp,
    output logic [ID_WIDTH-1:0] o_awid,
    output logic [ID_WIDTH-1:0] o_wid,
    input  logic [ID_WIDTH-1:0] i_bid
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    wbuf_entry_t      w_push_entry;
    wbuf_entry_t      w_head;
    wbuf_entry_t      w_mem [DEPTH];
    logic [DEPTH-1:0] w_valid;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_can_start;
    logic             w_awvalid;
    logic             w_wvalid;
    logic             w_aw_cplt;
    logic             w_w_cplt;
    logic             w_b_hs;
    logic             w_hit;
    logic             w_unused_par;

    logic             r_aw_done;
    logic             r_w_done;
    logic [OW-1:0]    r_out_cnt;
    logic             r_bus_err;

    assign w_push_entry = {i_push_addr, i_push_be, i_push_data};
    assign w_push       = i_push_valid && !w_full;

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (wbuf_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_valid (w_valid),
        .o_mem   (w_mem)
    );

    // A head that already has one channel done must finish even at the credit limit.
    assign w_can_start = !w_empty && (r_out_cnt < OW'(MAX_OUTSTANDING));
    assign w_awvalid   = !w_empty && !r_aw_done && (w_can_start || r_w_done);
    assign w_wvalid    = !w_empty && !r_w_done  && (w_can_start || r_aw_done);
    assign w_aw_cplt   = r_aw_done || (w_awvalid && i_axi3_wr_resp.awready);
    assign w_w_cplt    = r_w_done  || (w_wvalid  && i_axi3_wr_resp.wready);
    assign w_pop       = !w_empty && w_aw_cplt && w_w_cplt;
    assign w_b_hs      = i_axi3_wr_resp.bvalid;

    assign o_axi3_wr_req.awvalid = w_awvalid;
    assign o_axi3_wr_req.awaddr  = w_head.addr;
    assign o_axi3_wr_req.awlen   = 4'd0;
    assign o_axi3_wr_req.awsize  = AXI_SIZE_4B;
    assign o_axi3_wr_req.awburst = AXI_BURST_INCR;
    assign o_axi3_wr_req.awlock  = 2'b00;
    assign o_axi3_wr_req.awcache = 4'b0000;
    assign o_axi3_wr_req.awprot  = 3'b000;
    assign o_axi3_wr_req.wvalid  = w_wvalid;
    assign o_axi3_wr_req.wdata   = w_head.data;
    assign o_axi3_wr_req.wstrb   = w_head.be;
    assign o_axi3_wr_req.wlast   = 1'b1;
    assign o_axi3_wr_req.bready  = 1'b1;

    assign o_awid       = ID_WIDTH'(AXI_ID);
    assign o_wid        = ID_WIDTH'(AXI_ID);
    assign o_push_ready = !w_full;
    assign o_drained    = w_empty && (r_out_cnt == '0);
    assign o_bus_err    = r_bus_err;
    assign o_query_hit  = w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_out_cnt <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_aw_done <= w_pop ? 1'b0 : w_aw_cplt;
            r_w_done  <= w_pop ? 1'b0 : w_w_cplt;
            case ({w_pop, w_b_hs})
                2'b10:   r_out_cnt <= r_out_cnt + OW'(1);
                2'b01:   if (r_out_cnt != '0) r_out_cnt <= r_out_cnt - OW'(1);
                default: r_out_cnt <= r_out_cnt;
            endcase
            if (w_b_hs && (i_axi3_wr_resp.bresp != AXI_RESP_OKAY))
                r_bus_err <= 1'b1;
        end
    end

    // Word-granular match; byte enables are deliberately ignored so a hit is conservative.
    always_comb begin
        w_hit        = 1'b0;
        w_unused_par = (^i_bid) ^ (^i_query_addr[1:0]);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && (w_mem[i].addr[31:2] == i_query_addr[31:2]))
                w_hit = 1'b1;
            w_unused_par = w_unused_par ^ (^w_mem[i]);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi3_uncached_wbuf.sv
// ============================================================================
// tb_axi3_uncached_wbuf : directed self-checking bench for axi3_uncached_wbuf.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axi3_uncached_wbuf;
    import axi3_uncached_wbuf_pkg::*;

    logic          clk;
    logic          rst_n;
    logic          push_valid;
    logic          push_ready;
    logic [31:0]   push_addr;
    logic [3:0]    push_be;
    logic [31:0]   push_data;
    logic [31:0]   query_addr;
    logic          query_hit;
    logic          drained;
    logic          bus_err;
    axi3_wr_req_t  req;
    axi3_wr_resp_t resp;
    logic [3:0]    awid;
    logic [3:0]    wid;
    logic [3:0]    bid;

    int n_vec;
    int n_err;
    int n_aw;
    int n_w;
    int n_b;

    axi3_uncached_wbuf #(
        .DEPTH           (8),
        .ID_WIDTH        (4),
        .AXI_ID          (1),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_push_valid   (push_valid),
        .o_push_ready   (push_ready),
        .i_push_addr    (push_addr),
        .i_push_be      (push_be),
        .i_push_data    (push_data),
        .i_query_addr   (query_addr),
        .o_query_hit    (query_hit),
        .o_drained      (drained),
        .o_bus_err      (bus_err),
        .o_axi3_wr_req  (req),
        .i_axi3_wr_resp (resp),
        .o_awid         (awid),
        .o_wid          (wid),
        .i_bid          (bid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        push_valid = 1'b1;
        push_addr  = a;
        push_be    = be;
        push_data  = d;
        tick();
        push_valid = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0;
        push_valid = 1'b0; push_addr = '0; push_be = '0; push_data = '0;
        query_addr = '0; bid = '0;
        resp = '0;
        #3;
        chk("rst_push_ready", push_ready, 1);
        chk("rst_drained", drained, 1);
        chk("rst_query_hit", query_hit, 0);
        chk("rst_awvalid", req.awvalid, 0);
        chk("rst_wvalid", req.wvalid, 0);
        chk("rst_bready", req.bready, 1);
        chk("rst_bus_err", bus_err, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // 1: single store, both channels ready
        resp.awready = 1'b1; resp.wready = 1'b1;
        push(32'h1FD0_F000, 4'hF, 32'hDEAD_BEEF);
        query_addr = 32'h1FD0_F000;
        #1;
        chk("t1_awvalid", req.awvalid, 1);
        chk("t1_awaddr", req.awaddr, 32'h1FD0_F000);
        chk("t1_awlen", req.awlen, 0);
        chk("t1_awsize", req.awsize, 3'b010);
        chk("t1_awburst", req.awburst, 2'b01);
        chk("t1_awid", awid, 1);
        chk("t1_wvalid", req.wvalid, 1);
        chk("t1_wdata", req.wdata, 32'hDEAD_BEEF);
        chk("t1_wstrb", req.wstrb, 4'hF);
        chk("t1_wlast", req.wlast, 1);
        chk("t1_query_hit", query_hit, 1);
        chk("t1_drained0", drained, 0);
        tick();
        chk("t1_awvalid_after", req.awvalid, 0);
        chk("t1_wvalid_after", req.wvalid, 0);
        chk("t1_drained_wait", drained, 0);
        tick(); tick();
        chk("t1_drained_preB", drained, 0);
        resp.bvalid = 1'b1; resp.bresp = 2'b00;
        tick();
        resp.bvalid = 1'b0;
        chk("t1_drained1", drained, 1);

        // 2: W completes before AW
        resp.awready = 1'b0; resp.wready = 1'b1;
        push(32'h0000_0100, 4'h3, 32'h0000_0011);
        chk("t2_awvalid0", req.awvalid, 1);
        chk("t2_wvalid0", req.wvalid, 1);
        tick();
        chk("t2_wvalid_drop", req.wvalid, 0);
        chk("t2_awvalid_hold", req.awvalid, 1);
        chk("t2_awaddr_hold", req.awaddr, 32'h0000_0100);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t2_awvalid_stable", req.awvalid, 1);
            chk("t2_awaddr_stable", req.awaddr, 32'h0000_0100);
            chk("t2_wvalid_low", req.wvalid, 0);
        end
        resp.awready = 1'b1;
        tick();
        chk("t2_awvalid_popped", req.awvalid, 0);
        chk("t2_drained_out1", drained, 0);
        resp.bvalid = 1'b1;
        tick();
        resp.bvalid = 1'b0;
        chk("t2_drained1", drained, 1);

        // 3: fill to full with AW/W stalled, then drain in order
        resp.awready = 1'b0; resp.wready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) chk("t3_ready_before8", push_ready, 1);
            push(32'h0000_4000 + 32'(4 * k), 4'hF, 32'(k));
        end
        chk("t3_full", push_ready, 0);
        push(32'h0000_5000, 4'hF, 32'h0000_0055);
        chk("t3_still_full", push_ready, 0);
        query_addr = 32'h0000_5000;
        #1 chk("t3_9th_not_stored", query_hit, 0);
        query_addr = 32'h0000_401C;
        #1 chk("t3_8th_stored", query_hit, 1);
        resp.awready = 1'b1; resp.wready = 1'b1;
        n_aw = 0; n_w = 0; n_b = 0;
        for (int cyc = 0; cyc < 100 && n_b < 8; cyc++) begin
            resp.bvalid = (((n_aw < n_w) ? n_aw : n_w) > n_b);
            resp.bresp  = 2'b00;
            #1;
            if (req.awvalid) begin
                chk("t3_order_awaddr", req.awaddr, 32'h0000_4000 + 32'(4 * n_aw));
                n_aw++;
            end
            if (req.wvalid) begin
                chk("t3_order_wdata", req.wdata, 32'(n_w));
                n_w++;
            end
            if (resp.bvalid) n_b++;
            tick();
        end
        resp.bvalid = 1'b0;
        chk("t3_write_count", n_aw, 8);
        chk("t3_b_count", n_b, 8);
        chk("t3_drained", drained, 1);

        // 4: outstanding limit with B withheld
        push(32'h0000_6000, 4'hF, 32'h6000);
        push(32'h0000_6004, 4'hF, 32'h6004);
        push(32'h0000_6008, 4'hF, 32'h6008);
        chk("t4_blocked_aw", req.awvalid, 0);
        chk("t4_blocked_w", req.wvalid, 0);
        tick();
        chk("t4_still_blocked_aw", req.awvalid, 0);
        chk("t4_still_blocked_w", req.wvalid, 0);
        resp.bvalid = 1'b1;
        tick();
        resp.bvalid = 1'b0;
        chk("t4_third_aw", req.awvalid, 1);
        chk("t4_third_addr", req.awaddr, 32'h0000_6008);
        chk("t4_third_w", req.wvalid, 1);
        tick();
        chk("t4_empty_aw", req.awvalid, 0);
        resp.bvalid = 1'b1;
        tick(); tick();
        resp.bvalid = 1'b0;
        chk("t4_drained", drained, 1);

        // 5: address-hit query
        resp.awready = 1'b0; resp.wready = 1'b0;
        push(32'h0000_1000, 4'hF, 32'h1);
        push(32'h0000_2004, 4'hF, 32'h2);
        query_addr = 32'h0000_2006;
        #1 chk("t5_hit_2006", query_hit, 1);
        query_addr = 32'h0000_3000;
        #1 chk("t5_miss_3000", query_hit, 0);
        query_addr = 32'h0000_2006;
        resp.awready = 1'b1; resp.wready = 1'b1;
        tick();
        chk("t5_hit_after_first_pop", query_hit, 1);
        tick();
        chk("t5_miss_after_pop", query_hit, 0);
        query_addr = 32'h0000_1000;
        #1 chk("t5_miss_1000", query_hit, 0);
        resp.bvalid = 1'b1;
        tick(); tick();
        resp.bvalid = 1'b0;
        chk("t5_drained", drained, 1);

        // 6: error response on the second of three writes
        push(32'h0000_8000, 4'hF, 32'hA);
        push(32'h0000_8004, 4'hF, 32'hB);
        push(32'h0000_8008, 4'hF, 32'hC);
        resp.bvalid = 1'b1; resp.bresp = 2'b00;
        tick();
        chk("t6_no_err", bus_err, 0);
        resp.bresp = 2'b10;
        tick();
        chk("t6_err_set", bus_err, 1);
        resp.bresp = 2'b00;
        tick();
        resp.bvalid = 1'b0;
        chk("t6_err_sticky", bus_err, 1);
        chk("t6_drained", drained, 1);
        tick();
        chk("t6_err_sticky2", bus_err, 1);

        // asynchronous reset in the middle of a pending burst
        resp.awready = 1'b0; resp.wready = 1'b0;
        push(32'h0000_7000, 4'hF, 32'h70);
        push(32'h0000_7004, 4'hF, 32'h74);
        query_addr = 32'h0000_7004;
        #1;
        chk("rst2_pre_hit", query_hit, 1);
        chk("rst2_pre_awvalid", req.awvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst2_push_ready", push_ready, 1);
        chk("rst2_drained", drained, 1);
        chk("rst2_hit", query_hit, 0);
        chk("rst2_awvalid", req.awvalid, 0);
        chk("rst2_wvalid", req.wvalid, 0);
        chk("rst2_bus_err", bus_err, 0);
        #1 rst_n = 1'b1;
        tick();
        chk("rst2_after_release", drained, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
